// File: rtl/mmio_message_port_pkg.sv
// mmio_message_port shared constants: register offsets, STATUS
// bit positions, bus handshake states and the message width helper.
package mmio_message_port_pkg;

  localparam logic [5:0] OFF_OUT_X       = 6'h00;
  localparam logic [5:0] OFF_OUT_Y       = 6'h04;
  localparam logic [5:0] OFF_OUT_ELEMENT = 6'h08;
  localparam logic [5:0] OFF_STATUS      = 6'h0C;
  localparam logic [5:0] OFF_IN_X        = 6'h10;
  localparam logic [5:0] OFF_IN_Y        = 6'h14;
  localparam logic [5:0] OFF_IN_ELEMENT  = 6'h18;
  localparam logic [5:0] OFF_IN_POP      = 6'h1C;

  localparam int unsigned ST_OUT_FULL  = 0;
  localparam int unsigned ST_OUT_EMPTY = 1;
  localparam int unsigned ST_IN_PEND   = 2;
  localparam int unsigned ST_OVERFLOW  = 3;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_CHAN_LSB  = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RESP  = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  function automatic int unsigned msg_bits(
    input int unsigned cb,
    input int unsigned eb
  );
    return 2 * cb + eb;
  endfunction

endpackage

// File: rtl/mmio_message_port_fifo.sv
// Synchronous message FIFO with occupancy count; a push while full
// is dropped even when a pop happens in the same cycle.
module mmio_message_port_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_message_port.sv
// Memory-mapped message port: buffered output FIFO, round-robin input
// arbiter, STATUS register. MMIO_MESSAGE_PORT_STALL_EN: stall when full.
module mmio_message_port
  import mmio_message_port_pkg::*;
#(
  parameter int unsigned NUM_IN       = 2,
  parameter int unsigned COORD_BITS   = 8,
  parameter int unsigned ELEMENT_BITS = 32,
  parameter int unsigned OUT_DEPTH    = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h2000_0000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           mem_valid,
  input  logic [31:0]                    mem_addr,
  input  logic [31:0]                    mem_wdata,
  input  logic [3:0]                     mem_wstrb,
  output logic                           mem_ready,
  output logic [31:0]                    mem_rdata,
  output logic [COORD_BITS-1:0]          out_x,
  output logic [COORD_BITS-1:0]          out_y,
  output logic [ELEMENT_BITS-1:0]        out_element,
  output logic                           out_valid,
  input  logic                           out_ready,
  input  logic [NUM_IN*COORD_BITS-1:0]   in_x,
  input  logic [NUM_IN*COORD_BITS-1:0]   in_y,
  input  logic [NUM_IN*ELEMENT_BITS-1:0] in_element,
  input  logic [NUM_IN-1:0]              in_valid,
  output logic [NUM_IN-1:0]              in_ready,
  output logic                           in_pending
);

  localparam int unsigned CB  = COORD_BITS;
  localparam int unsigned EB  = ELEMENT_BITS;
  localparam int unsigned MB  = msg_bits(COORD_BITS, ELEMENT_BITS);
  localparam int unsigned CW  = $clog2(OUT_DEPTH) + 1;

  logic [1:0]    state_q, state_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CB-1:0] ox_q, ox_d;
  logic [CB-1:0] oy_q, oy_d;
  logic          ovf_q, ovf_d;
  logic          pend_q, pend_d;
  logic          pop_q, pop_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    chan_q, chan_d;
  logic [CB-1:0] ix_q, ix_d;
  logic [CB-1:0] iy_q, iy_d;
  logic [EB-1:0] ie_q, ie_d;

  logic [31:0]   off_full;
  logic [5:0]    off;
  logic          hit;
  logic          accept;
  logic          wr;
  logic [31:0]   status;
  logic [31:0]   rd_val;

  logic          f_push;
  logic          f_pop;
  logic [MB-1:0] f_wdata;
  logic [MB-1:0] f_rdata;
  logic [CW-1:0] f_count;
  logic          f_full;
  logic          f_empty;

  logic [7:0]    valid_pad;
  logic [3:0]    rr_j;
  logic [3:0]    nxt_ptr;
  logic          gnt_found;
  logic [2:0]    gnt_idx;
  logic          arb_go;
  logic [CB-1:0] sel_x;
  logic [CB-1:0] sel_y;
  logic [EB-1:0] sel_e;
  logic          unused_wdata;

  assign unused_wdata = ^mem_wdata;

  // Window decode by subtraction so BASE_ADDR need only be word-aligned.
  assign off_full = mem_addr - BASE_ADDR;
  assign hit      = mem_valid && (off_full[31:6] == '0);
  assign off      = off_full[5:0];
  assign accept   = hit && (state_q == S_IDLE);
  assign wr       = |mem_wstrb;

  assign f_wdata = {ox_q, oy_q, mem_wdata[EB-1:0]};
  assign f_pop   = out_valid && out_ready;

  mmio_message_port_fifo #(
    .WIDTH (MB),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (f_push),
    .wdata_i (f_wdata),
    .pop_i   (f_pop),
    .rdata_o (f_rdata),
    .count_o (f_count),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign out_valid   = !f_empty;
  assign out_x       = f_empty ? '0 : f_rdata[MB-1 -: CB];
  assign out_y       = f_empty ? '0 : f_rdata[EB +: CB];
  assign out_element = f_empty ? '0 : f_rdata[EB-1:0];

  assign mem_ready  = (state_q == S_RESP);
  assign mem_rdata  = rdata_q;
  assign in_pending = pend_q;

  always_comb begin
    status = '0;
    status[ST_OUT_FULL]        = f_full;
    status[ST_OUT_EMPTY]       = f_empty;
    status[ST_IN_PEND]         = pend_q;
    status[ST_OVERFLOW]        = ovf_q;
    status[ST_COUNT_LSB +: 8]  = 8'(f_count);
    status[ST_CHAN_LSB +: 3]   = chan_q;
  end

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_STATUS:     rd_val = status;
      OFF_IN_X:       rd_val = 32'(ix_q);
      OFF_IN_Y:       rd_val = 32'(iy_q);
      OFF_IN_ELEMENT: rd_val = 32'(ie_q);
      default:        rd_val = '0;
    endcase
  end

  assign valid_pad = 8'(in_valid);

  // Rotating priority: first requester at or after the pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_j      = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      rr_j = 4'(ptr_q) + 4'(k);
      if (rr_j >= 4'(NUM_IN)) rr_j = rr_j - 4'(NUM_IN);
      if (!gnt_found && valid_pad[rr_j[2:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_j[2:0];
      end
    end
  end

  assign arb_go  = reset_n && !pend_q && gnt_found;
  assign nxt_ptr = 4'(gnt_idx) + 4'd1;

  always_comb begin
    in_ready = '0;
    sel_x    = '0;
    sel_y    = '0;
    sel_e    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_idx == 3'(i)) begin
        in_ready[i] = arb_go;
        sel_x = in_x[i*CB +: CB];
        sel_y = in_y[i*CB +: CB];
        sel_e = in_element[i*EB +: EB];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = '0;
    ox_d    = ox_q;
    oy_d    = oy_q;
    ovf_d   = ovf_q;
    pend_d  = pend_q;
    pop_d   = pop_q;
    ptr_d   = ptr_q;
    chan_d  = chan_q;
    ix_d    = ix_q;
    iy_d    = iy_q;
    ie_d    = ie_q;
    f_push  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RESP;
          if (!wr) begin
            rdata_d = rd_val;
          end else begin
            case (off)
              OFF_OUT_X: ox_d = mem_wdata[CB-1:0];
              OFF_OUT_Y: oy_d = mem_wdata[CB-1:0];
              OFF_OUT_ELEMENT: begin
                if (!f_full) begin
                  f_push = 1'b1;
                end else begin
`ifdef MMIO_MESSAGE_PORT_STALL_EN
                  state_d = S_STALL;
`else
                  ovf_d = 1'b1;
`endif
                end
              end
              OFF_STATUS: ovf_d = 1'b0;
              OFF_IN_POP: pop_d = 1'b1;
              default: ;
            endcase
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        pop_d   = 1'b0;
        // Holding register frees only after the pop completes.
        if (pop_q) pend_d = 1'b0;
      end
      S_STALL: begin
        if (!f_full) begin
          f_push  = 1'b1;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (arb_go) begin
      pend_d = 1'b1;
      chan_d = gnt_idx;
      ptr_d  = (nxt_ptr == 4'(NUM_IN)) ? 3'd0 : nxt_ptr[2:0];
      ix_d   = sel_x;
      iy_d   = sel_y;
      ie_d   = sel_e;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      pop_q   <= 1'b0;
      ptr_q   <= '0;
      chan_q  <= '0;
      ix_q    <= '0;
      iy_q    <= '0;
      ie_q    <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      pop_q   <= pop_d;
      ptr_q   <= ptr_d;
      chan_q  <= chan_d;
      ix_q    <= ix_d;
      iy_q    <= iy_d;
      ie_q    <= ie_d;
    end
  end

endmodule

// File: tb/tb_mmio_message_port.sv
// Directed bench for mmio_message_port with read-data and
// output-message scoreboards (default build, no stall).
module tb_mmio_message_port;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [7:0]  out_x;
  logic [7:0]  out_y;
  logic [31:0] out_element;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] in_x = '0;
  logic [15:0] in_y = '0;
  logic [63:0] in_element = '0;
  logic [1:0]  in_valid = '0;
  logic [1:0]  in_ready;
  logic        in_pending;

  int vec = 0;
  int miss = 0;
  logic [31:0] rd_q [$];
  logic [47:0] out_q [$];
  logic        pend_at_ready;

  always #5 clk = ~clk;

  mmio_message_port #(
    .NUM_IN       (2),
    .COORD_BITS   (8),
    .ELEMENT_BITS (32),
    .OUT_DEPTH    (4),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_element (out_element),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_element  (in_element),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pending  (in_pending)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp);
    int n = 0;
    logic [31:0] e;
    rd_q.push_back(exp);
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    mem_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready && n < 20);
    e = rd_q.pop_front();
    chk({tag, "_lat"}, 64'(n), 64'd1);
    chk({tag, "_data"}, 64'(mem_rdata), 64'(e));
    pend_at_ready = in_pending;
    mem_valid = 1'b0;
    mem_wstrb = '0;
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(mem_ready), 64'd0);
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (out_q.size() == 0)
        chk("out_extra", 64'(out_valid), 64'd0);
      else
        chk("out_msg", 64'({out_x, out_y, out_element}),
            64'(out_q.pop_front()));
    end
    if (in_pending) chk("in_ready_hold", 64'(in_ready), 64'd0);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(mem_ready), 64'd0);
    chk("rst_rdata", 64'(mem_rdata), 64'd0);
    chk("rst_out", 64'({out_valid, out_x, out_y, out_element}), 64'd0);
    chk("rst_in", 64'({in_ready, in_pending}), 64'd0);
    reset_n = 1'b1;

    bus("rd_in_x0", BASE + 32'h10, 0, 4'h0, 32'h0);
    bus("rd_unmap", BASE + 32'h3C, 0, 4'h0, 32'h0);
    bus("rd_st0", BASE + 32'h0C, 0, 4'h0, 32'h2);

    out_ready = 1'b1;
    bus("wr_x", BASE + 32'h00, 32'd3, 4'hF, 32'h0);
    bus("wr_y", BASE + 32'h04, 32'd5, 4'hF, 32'h0);
    out_q.push_back({8'd3, 8'd5, 32'hDEAD});
    bus("wr_e", BASE + 32'h08, 32'hDEAD, 4'hF, 32'h0);
    chk("out_one_cycle", 64'(out_valid), 64'd0);
    chk("out_q1", 64'(out_q.size()), 64'd0);
    bus("rd_st1", BASE + 32'h0C, 0, 4'h0, 32'h2);

    out_ready = 1'b0;
    bus("wr_x2", BASE + 32'h00, 32'd7, 4'hF, 32'h0);
    bus("wr_y2", BASE + 32'h04, 32'd9, 4'hF, 32'h0);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) out_q.push_back({8'd7, 8'd9, 32'h100 + 32'(k)});
      bus("wr_fill", BASE + 32'h08, 32'h100 + 32'(k), 4'h1, 32'h0);
    end
    bus("rd_st_ovf", BASE + 32'h0C, 0, 4'h0, 32'h409);
    bus("wr_st", BASE + 32'h0C, 0, 4'hF, 32'h0);
    bus("rd_st_clr", BASE + 32'h0C, 0, 4'h0, 32'h401);
    out_ready = 1'b1;
    n = 0;
    while ((out_q.size() != 0 || out_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(out_q.size()), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);
    bus("rd_st2", BASE + 32'h0C, 0, 4'h0, 32'h2);

    in_x       = {8'h11, 8'h10};
    in_y       = {8'h21, 8'h20};
    in_element = {32'hA001, 32'hA000};
    in_valid   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!in_pending && n < 10);
      chk("arb_pend", 64'(in_pending), 64'd1);
      bus("rd_st_arb", BASE + 32'h0C, 0, 4'h0,
          32'h6 | (32'(k % 2) << 16));
      bus("rd_ix", BASE + 32'h10, 0, 4'h0, 32'h10 + 32'(k % 2));
      bus("rd_iy", BASE + 32'h14, 0, 4'h0, 32'h20 + 32'(k % 2));
      bus("rd_ie", BASE + 32'h18, 0, 4'h0, 32'hA000 + 32'(k % 2));
      bus("wr_pop", BASE + 32'h1C, 0, 4'hF, 32'h0);
      chk("pend_at_ready", 64'(pend_at_ready), 64'd1);
      chk("regrant", 64'({in_pending, in_ready}),
          64'(2'b01 << ((k + 1) % 2)));
    end
    @(negedge clk);
    in_valid = 2'b00;
    chk("pend_again", 64'(in_pending), 64'd1);

    mem_addr  = BASE + 32'd64;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("oow", 64'({mem_ready, mem_rdata}), 64'd0);
    end
    mem_valid = 1'b0;
    @(negedge clk);

    out_ready = 1'b0;
    bus("wr_x3", BASE + 32'h00, 32'd1, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) begin
      out_q.push_back({8'd1, 8'd9, 32'h200 + 32'(k)});
      bus("wr_fill2", BASE + 32'h08, 32'h200 + 32'(k), 4'hF, 32'h0);
    end
    chk("full_before_rst", 64'(out_valid), 64'd1);
    mem_addr  = BASE + 32'h08;
    mem_wdata = 32'h300;
    mem_wstrb = 4'hF;
    mem_valid = 1'b1;
    reset_n   = 1'b0;
    @(negedge clk);
    chk("rstx_ready", 64'(mem_ready), 64'd0);
    chk("rstx_out", 64'(out_valid), 64'd0);
    chk("rstx_pend", 64'(in_pending), 64'd0);
    out_q.delete();
    mem_valid = 1'b0;
    mem_wstrb = '0;
    reset_n   = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    bus("rd_st_end", BASE + 32'h0C, 0, 4'h0, 32'h2);
    bus("rd_ix_end", BASE + 32'h10, 0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("end_out", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/mmio_message_port.md
Name: mmio_message_port

Overview:
- Parametrised memory-mapped message interface between a picorv32 native memory bus and the matrix message network.
- Replaces fixed single-channel, unbuffered matrix I/O decoding with:
  - a buffered output message FIFO with ready/valid backpressure;
  - N input channels with round-robin arbitration;
  - a status register.
- Sits beside core RAM; the system decoder routes only the BASE_ADDR window here.

Parameters:
- NUM_IN, 2, number of input message channels (1..8).
- COORD_BITS, 8, x/y coordinate width.
- ELEMENT_BITS, 32, element width (<=32).
- OUT_DEPTH, 4, output FIFO depth (power of 2, >=2).
- BASE_ADDR, 32'h2000_0000, window base; window is 64 bytes, word-aligned.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- mem_valid  in  1  core request valid, held until mem_ready
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  write strobes; 0 = read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- out_x / out_y  out  COORD_BITS  outgoing message coordinates
- out_element  out  ELEMENT_BITS  outgoing element
- out_valid  out  1  FIFO not empty
- out_ready  in  1  network accepts
- in_x / in_y  in  NUM_IN*COORD_BITS  packed channel coordinates, channel i at [i*COORD_BITS +: COORD_BITS]
- in_element  in  NUM_IN*ELEMENT_BITS  packed elements
- in_valid  in  NUM_IN  channel offers message
- in_ready  out  NUM_IN  one-hot grant
- in_pending  out  1  holding register full (interrupt-style level)

Behaviour:
- Clock and reset: clock clk; reset reset_n, synchronous, active-low.
- Reset state: all outputs 0, FIFO empty, holding register cleared, arbiter pointer = 0, overflow flag = 0. Reset mid-transaction abandons the request; no mem_ready is issued.
- Hit: mem_valid && addr in [BASE_ADDR, BASE_ADDR+63]. Non-hit requests are ignored; mem_ready and mem_rdata stay 0.
- Accept: on a hit with !mem_ready; mem_ready=1 on the next cycle for exactly one cycle. No accept occurs in the cycle mem_ready is high. Read latency = 1 cycle.
- Register map (offset, access):
  - 0x00 OUT_X W
  - 0x04 OUT_Y W
  - 0x08 OUT_ELEMENT W: pushes {OUT_X, OUT_Y, wdata} into the FIFO
  - 0x0C STATUS R/W, bits:
    - [0] out_full
    - [1] out_empty
    - [2] in_pending
    - [3] overflow
    - [15:8] out_count
    - [18:16] in_channel
    - Any write clears overflow.
  - 0x10 IN_X R
  - 0x14 IN_Y R
  - 0x18 IN_ELEMENT R
  - 0x1C IN_POP W: clears in_pending
- Unmapped offsets: read 0, write ignored, mem_ready still pulses.
- Read values are zero-extended to 32 bits. Writes are treated as whole-word when any strobe is set.
- Output FIFO:
  - out_valid = !empty.
  - Pop on out_valid && out_ready.
  - Full is evaluated on the registered count. A push while full is rejected even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves the count unchanged.
- Input arbiter:
  - Runs only while in_pending=0.
  - Grants the lowest index >= pointer with in_valid, wrapping modulo NUM_IN; asserts that in_ready for one cycle.
  - On transfer: captures the channel's message and index, sets in_pending, pointer = grant+1 mod NUM_IN.
  - While in_pending=1, in_ready=0.
  - After an IN_POP write, arbitration resumes the cycle after mem_ready.
  - IN_* reads when not pending return the last captured values.

Optional Feature:
- Macro MMIO_MESSAGE_PORT_STALL_EN.
- Defined: an OUT_ELEMENT write while full withholds mem_ready until the FIFO is not full, then pushes and pulses mem_ready the following cycle; overflow always reads 0.
- Undefined: the write completes normally, the message is dropped, and sticky overflow is set.

Decomposition:
- Shared header message_port.vh holds:
  - register offset constants;
  - STATUS bit positions;
  - MSG_BITS = 2*COORD_BITS+ELEMENT_BITS.
- One sub-module, message_fifo: synchronous FIFO parameterised by width and depth, with count, full and empty outputs.

Test Plan:
- Write OUT_X=3, OUT_Y=5, OUT_ELEMENT=0xDEAD with out_ready=1 -> out_valid for 1 cycle with x=3, y=5, element=0xDEAD; STATUS reads out_empty=1.
- out_ready=0, five OUT_ELEMENT writes with OUT_DEPTH=4 -> without macro: STATUS.overflow=1, out_count=4, then 4 messages drained in order. With macro: 5th write stalls until out_ready=1, then all 5 delivered.
- NUM_IN=2, in_valid=2'b11 continuously, repeated read/IN_POP -> in_channel alternates 0,1,0,1; in_ready never asserted while in_pending=1.
- Read 0x10 with in_pending=0 after reset -> mem_rdata=0, mem_ready pulses 1 cycle after accept; unmapped 0x3C read -> 0.
- Access to BASE_ADDR+64 -> mem_ready stays 0 for 10 cycles.
- reset_n=0 during a stalled write -> mem_ready=0, FIFO empty, in_pending=0 next cycle.
